// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes structured MIPS instruction requests into 32-bit
// words and streams them into instruction memory through a one-cycle write stage.
module instruction_encoder #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              inValid,
    output logic              inReady,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memData,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [CNT_W-1:0]   ptr;
    logic               weQ;
    logic               accept;
    logic               illegal;
    logic               lastWord;
    logic [31:0]        encoded;

    // Request decode: illegal-op detection and instruction word encoding
    always_comb begin
        encoded = '0;
        illegal = (op >= 4'd9) || ((op == 4'd0) && (funct == 6'd8));
        case (op)
            4'd0:    encoded = {6'd0, rs, rt, rd, 5'd0, funct};
            4'd1:    encoded = {6'd0, rs, 15'd0, 6'd8};
            4'd2:    encoded = {6'd4, rs, rt, imm};
            4'd3:    encoded = {6'd5, rs, rt, imm};
            4'd4:    encoded = {6'd35, rs, rt, imm};
            4'd5:    encoded = {6'd43, rs, rt, imm};
            4'd6:    encoded = {6'd8, rs, rt, imm};
            4'd7:    encoded = {6'd13, rs, rt, imm};
            4'd8:    encoded = {6'd2, target};
            default: encoded = '0;
        endcase
    end

    // start always wins over a same-cycle request
    assign accept   = (state == LOAD) && inValid && !start;
    assign lastWord = (ptr == CNT_W'(DEPTH - 1));

    // Next-state logic
    always_comb begin
        stateNext = state;
        if (start) begin
            stateNext = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (illegal) begin
                            stateNext = ERR;
                        end else if (lastWord) begin
                            stateNext = FULL;
                        end
                    end
                end
                default: stateNext = state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Write pipeline and address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            weQ     <= 1'b0;
            memAddr <= '0;
            memData <= '0;
        end else begin
            weQ <= accept && !illegal;
            if (start) begin
                ptr <= '0;
            end else if (accept && !illegal) begin
                ptr     <= ptr + CNT_W'(1);
                memAddr <= ptr[ADDR_W-1:0];
                memData <= encoded;
            end
        end
    end

    // A start or reset in the write cycle cancels the pending write
    assign memWe   = weQ && !start && !reset;
    assign inReady = (state == LOAD);
    assign full    = (state == FULL);
    assign err     = (state == ERR);
    assign count   = ptr;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: randomized and directed checks of instruction_encoder
// against a cycle-level reference model of the load protocol.
module tb_instruction_encoder;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              inValid;
    logic              inReady;
    logic [3:0]        op;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memData;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit          mLoad = 0;
    bit          mFull = 0;
    bit          mErr  = 0;
    int          mPtr  = 0;
    bit          mWe   = 0;
    int          mAddr = 0;
    logic [31:0] mData = '0;

    always #5 clk = ~clk;

    instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .inValid(inValid), .inReady(inReady),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .memWe(memWe), .memAddr(memAddr), .memData(memData), .count(count),
        .full(full), .err(err)
    );

    function automatic logic [31:0] refEncode(int o, int s, int t, int d, int f, int im, int tg);
        int unsigned opc [0:8] = '{0, 0, 4, 5, 35, 43, 8, 13, 2};
        int unsigned w;
        if (o == 0)      w = (s << 21) + (t << 16) + (d << 11) + f;
        else if (o == 1) w = (s << 21) + 8;
        else if (o == 8) w = (2 << 26) + tg;
        else             w = (opc[o] << 26) + (s << 21) + (t << 16) + im;
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expectWord(string tag, int a, logic [31:0] d);
        chk({tag, ".we"}, 32'(memWe), 32'd1);
        chk({tag, ".addr"}, 32'(memAddr), 32'(a));
        chk({tag, ".data"}, memData, d);
    endtask

    task automatic setReq(int o, int s, int t, int d, int f, int im, int tg);
        op = 4'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d);
        funct = 6'(f); imm = 16'(im); target = 26'(tg);
    endtask

    task automatic randLegal();
        setReq($urandom_range(0, 8), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
               $urandom_range(0, 32'h3FF_FFFF));
        if (op == 4'd0 && funct == 6'd8) funct = 6'h20;
    endtask

    // one clock: check this cycle's outputs, clock, advance the model
    task automatic cycle();
        bit acc;
        bit bad;
        #2;
        chk("inReady", 32'(inReady), 32'(mLoad));
        chk("memWe", 32'(memWe), 32'(mWe && !start && !reset));
        chk("memAddr", 32'(memAddr), 32'(mAddr));
        chk("memData", memData, mData);
        chk("count", 32'(count), 32'(mPtr));
        chk("full", 32'(full), 32'(mFull));
        chk("err", 32'(err), 32'(mErr));
        acc = mLoad && inValid && !start;
        bad = (op >= 9) || (op == 0 && funct == 8);
        @(posedge clk);
        if (reset) begin
            mLoad = 0; mFull = 0; mErr = 0; mPtr = 0; mWe = 0; mAddr = 0; mData = '0;
        end else if (start) begin
            mLoad = 1; mFull = 0; mErr = 0; mPtr = 0; mWe = 0;
        end else if (acc && bad) begin
            mLoad = 0; mErr = 1; mWe = 0;
        end else if (acc) begin
            mWe = 1; mAddr = mPtr;
            mData = refEncode(op, rs, rt, rd, funct, imm, target);
            mPtr++;
            if (mPtr == DEPTH) begin
                mFull = 1; mLoad = 0;
            end
        end else begin
            mWe = 0;
        end
        #1;
    endtask

    task automatic pulseStart();
        start = 1; inValid = 0; cycle(); start = 0;
    endtask

    initial begin
        reset = 1; start = 0; inValid = 0;
        setReq(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        cycle();
        reset = 0;
        // requests are ignored in IDLE
        inValid = 1; randLegal(); cycle(); cycle();
        chk("idleCount", 32'(count), 32'd0);

        // back-to-back R-type then addi, then remaining opcodes
        pulseStart();
        inValid = 1; setReq(0, 1, 2, 3, 32'h20, 0, 0); cycle();
        expectWord("rtype", 0, 32'h00221820);
        setReq(6, 1, 2, 0, 0, 5, 0); cycle();
        expectWord("addi", 1, 32'h20220005);
        chk("count2", 32'(count), 32'd2);
        setReq(4, 29, 8, 0, 0, 4, 0); cycle();
        expectWord("lw", 2, 32'h8FA80004);
        setReq(5, 29, 8, 0, 0, 4, 0); cycle();
        expectWord("sw", 3, 32'hAFA80004);
        setReq(1, 31, 0, 0, 0, 0, 0); cycle();
        expectWord("jr", 4, 32'h03E00008);
        setReq(3, 1, 2, 0, 0, 32'hFFFF, 0); cycle();
        expectWord("bne", 5, 32'h1422FFFF);
        setReq(8, 0, 0, 0, 0, 0, 32'h10); cycle();
        expectWord("j", 6, 32'h08000010);
        inValid = 0; cycle();

        // random valid gaps
        pulseStart();
        for (int i = 0; i < 60; i++) begin
            inValid = 1'($urandom_range(0, 1));
            randLegal();
            cycle();
        end
        inValid = 0; cycle();

        // fill to DEPTH, then further requests ignored
        pulseStart();
        inValid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            randLegal();
            cycle();
        end
        chk("fullSet", 32'(full), 32'd1);
        chk("fullReady", 32'(inReady), 32'd0);
        chk("fullCount", 32'(count), 32'(DEPTH));
        chk("fullAddr", 32'(memAddr), 32'(DEPTH - 1));
        for (int i = 0; i < 3; i++) begin
            randLegal(); cycle();
        end
        inValid = 0;

        // illegal op >= 9
        pulseStart();
        inValid = 1; setReq(9 + $urandom_range(0, 6), 1, 2, 3, 4, 5, 6); cycle();
        inValid = 0;
        chk("errOp", 32'(err), 32'd1);
        chk("errWe", 32'(memWe), 32'd0);
        cycle(); cycle();
        // illegal R-type with funct 8
        pulseStart();
        inValid = 1; setReq(4, 3, 4, 0, 0, 7, 0); cycle();
        setReq(0, 1, 2, 3, 8, 0, 0); cycle();
        inValid = 0;
        chk("errFunct", 32'(err), 32'd1);
        chk("errReady", 32'(inReady), 32'd0);
        cycle();
        pulseStart();
        chk("errClr", 32'(err), 32'd0);
        chk("ptrClr", 32'(count), 32'd0);

        // start right after an accept cancels that write
        inValid = 1; randLegal(); cycle();
        start = 1; cycle();
        start = 0; setReq(7, 5, 6, 0, 0, 32'h1234, 0); cycle();
        expectWord("afterStart", 0, 32'h34A61234);
        inValid = 0; cycle();

        // reset mid-stream
        inValid = 1;
        for (int i = 0; i < 4; i++) begin
            randLegal(); cycle();
        end
        reset = 1; cycle();
        chk("rstWe", 32'(memWe), 32'd0);
        chk("rstAddr", 32'(memAddr), 32'd0);
        chk("rstData", memData, 32'd0);
        chk("rstCount", 32'(count), 32'd0);
        reset = 0; inValid = 0;
        cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
